// File: rtl/pixel_config_pkg.sv
// Shared definitions for the MIC4 pixel-config serial link (receiver and serializer).
package pixel_config_pkg;

  localparam int PC_DATA_WIDTH = 15;
  localparam int PC_CNT_WIDTH  = 4;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'b0001,
    RX_SHIFT = 4'b0010,
    RX_WRITE = 4'b0100,
    RX_PEND  = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/pixel_config_sync_edge.sv
// Two-flop synchronizer for S_CLK/S_DATA plus S_CLK rising-edge detect.
// Data is taken from the same stage as the detected edge so the bit lines up with it.
module pixel_config_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic sdata_in,
  output logic rise,
  output logic data
);

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdata_s1_q, sdata_s2_q;

  // synchronizer chain; resets to idle level so no false edge follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_q  <= RST_VAL;
      sclk_s2_q  <= RST_VAL;
      sclk_s3_q  <= RST_VAL;
      sdata_s1_q <= RST_VAL;
      sdata_s2_q <= RST_VAL;
    end else begin
      sclk_s1_q  <= sclk_in;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdata_s1_q <= sdata_in;
      sdata_s2_q <= sdata_s1_q;
    end
  end

  assign rise = sclk_s2_q & ~sclk_s3_q;
  assign data = sdata_s2_q;

endmodule

// File: rtl/pixel_config_receiver.sv
// Deserializer for the MIC4 pixel-config link feeding a readback FIFO.
// Optional mid-word timeout: define PIXEL_CONFIG_RX_TIMEOUT_EN.
module pixel_config_receiver
  import pixel_config_pkg::*;
#(
  parameter int DATA_WIDTH      = PC_DATA_WIDTH,
  parameter int SHIFT_DIRECTION = 1,
  parameter int CNT_WIDTH       = PC_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  CLEAR,
  input  logic                  S_CLK,
  input  logic                  S_DATA,
  input  logic                  FULL,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  WR_FIFO,
  output logic                  BUSY,
  output logic [15:0]           WORD_CNT,
  output logic                  OVERRUN,
  output logic                  FRAME_ERR
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, count_inc_s;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  wr_fifo_s;
  logic                  rise_s, bit_s;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
    if (SHIFT_DIRECTION != 0) return {w[DATA_WIDTH-2:0], b};
    else                      return {b, w[DATA_WIDTH-1:1]};
  endfunction

  pixel_config_sync_edge #(.RST_VAL(1'b1)) u_sync (
    .clk      (CLK_IN),
    .rst      (RESET),
    .sclk_in  (S_CLK),
    .sdata_in (S_DATA),
    .rise     (rise_s),
    .data     (bit_s)
  );

  assign count_inc_s = count_q + CNT_ONE;

`ifdef PIXEL_CONFIG_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;

  // idle-cycle counter, only meaningful while mid-word
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      tmo_q       <= {TW{1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign FRAME_ERR = frame_err_q;
`else
  logic [31:0] tmo_unused_s;
  assign tmo_unused_s = TIMEOUT_CYCLES;
  assign FRAME_ERR    = 1'b0;
`endif

  // next-state, datapath and strobe; the strobe is gated by FULL in the same cycle
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    word_cnt_d = word_cnt_q;
    overrun_d  = overrun_q;
    busy_d     = (state_q == RX_PEND) || FULL;
    wr_fifo_s  = (state_q == RX_WRITE) && !FULL && !CLEAR;
`ifdef PIXEL_CONFIG_RX_TIMEOUT_EN
    frame_err_d = frame_err_q;
    tmo_d       = {TW{1'b0}};
    if ((state_q == RX_SHIFT) && !rise_s) tmo_d = tmo_q + TW'(1);
`endif
    if (CLEAR) begin
      state_d = RX_IDLE;
      count_d = {CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        RX_IDLE: begin
          count_d = {CNT_WIDTH{1'b0}};
          if (rise_s) begin
            shreg_d = shift_in({DATA_WIDTH{1'b0}}, bit_s);
            count_d = CNT_ONE;
            state_d = RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (rise_s) begin
            shreg_d = shift_in(shreg_q, bit_s);
            count_d = count_inc_s;
            if (count_inc_s == CNT_LAST) begin
              data_out_d = shreg_d;
              count_d    = {CNT_WIDTH{1'b0}};
              state_d    = FULL ? RX_PEND : RX_WRITE;
            end
`ifdef PIXEL_CONFIG_RX_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            count_d     = {CNT_WIDTH{1'b0}};
            state_d     = RX_IDLE;
`endif
          end
        end
        RX_WRITE: begin
          if (FULL) begin
            state_d = RX_PEND;
            if (rise_s) overrun_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (rise_s) begin
              shreg_d = shift_in({DATA_WIDTH{1'b0}}, bit_s);
              count_d = CNT_ONE;
              state_d = RX_SHIFT;
            end else begin
              count_d = {CNT_WIDTH{1'b0}};
              state_d = RX_IDLE;
            end
          end
        end
        RX_PEND: begin
          if (rise_s) overrun_d = 1'b1;
          if (!FULL) state_d = RX_WRITE;
        end
        default: begin
          state_d = RX_IDLE;
          count_d = {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q    <= RX_IDLE;
      count_q    <= {CNT_WIDTH{1'b0}};
      shreg_q    <= {DATA_WIDTH{1'b0}};
      data_out_q <= {DATA_WIDTH{1'b0}};
      word_cnt_q <= 16'd0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign DATA_OUT = data_out_q;
  assign WR_FIFO  = wr_fifo_s;
  assign BUSY     = busy_q;
  assign WORD_CNT = word_cnt_q;
  assign OVERRUN  = overrun_q;

endmodule
